// File: rtl/destruct_line_ctrl_pkg.sv
// Shared types and constants for the destructor line/frame sequencer.
package destruct_ctrl_pkg;

  localparam int GAP_MIN    = 1;
  localparam int DEFAULT_HW = 16;
  localparam int DEFAULT_VW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_RUN   = 3'd2,
    ST_LEND  = 3'd3,
    ST_GAPW  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Width of a down-counter that must hold gap-1.
  function automatic int gap_cnt_width(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/destruct_line_ctrl_if.sv
// Sequencer <-> destructor/pixel-sink signal bundle.
interface destruct_line_ctrl_if;
  logic dst_ord_en;
  logic dst_ialign;
  logic dst_force_rd;
  logic fifo_empty;
  logic pix_ready;
  logic pix_valid;
  logic pix_sof;
  logic pix_eol;

  modport master (
    output dst_ord_en, dst_ialign, dst_force_rd, pix_valid, pix_sof, pix_eol,
    input  fifo_empty, pix_ready
  );

  modport slave (
    input  dst_ord_en, dst_ialign, dst_force_rd, pix_valid, pix_sof, pix_eol,
    output fifo_empty, pix_ready
  );
endinterface

// File: rtl/destruct_line_ctrl_xy_cnt.sv
// Horizontal/vertical pixel counters with terminal-count flags against the latched geometry.
module dctrl_xy_cnt
  import destruct_ctrl_pkg::*;
#(
  parameter int HW = DEFAULT_HW,
  parameter int VW = DEFAULT_VW
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          h_inc,
  input  logic          h_clr,
  input  logic          v_inc,
  input  logic          v_clr,
  input  logic [HW-1:0] h_total,
  input  logic [VW-1:0] v_total,
  output logic          h_last,
  output logic          v_last
);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (h_clr)      hcnt <= '0;
      else if (h_inc) hcnt <= hcnt + HW'(1);
      if (v_clr)      vcnt <= '0;
      else if (v_inc) vcnt <= vcnt + VW'(1);
    end
  end

  // Totals are never zero once latched, so total-1 cannot underflow.
  assign h_last = (hcnt == h_total - HW'(1));
  assign v_last = (vcnt == v_total - VW'(1));

endmodule

// File: rtl/destruct_line_ctrl.sv
// Frame/line sequencer driving the wide-word-to-pixel destructor.
// DESTRUCT_LINE_ALIGN_EN: force a fresh wide word at every line end (default: only the last line).
//
// state | meaning
// IDLE  | waiting for start
// ALIGN | one-cycle word-alignment pulse, counters cleared
// RUN   | issuing pixel read enables
// LEND  | line end, optional force-read
// GAPW  | inter-line idle gap
// DONE  | frame completion pulse
module destruct_line_ctrl
  import destruct_ctrl_pkg::*;
#(
  parameter int HW  = DEFAULT_HW,
  parameter int VW  = DEFAULT_VW,
  parameter int GAP = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [HW-1:0]         cfg_hactive,
  input  logic [VW-1:0]         cfg_vactive,
  input  logic                  start,
  input  logic                  abort,
  destruct_line_ctrl_if.master  dst,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cfg_err
);

  localparam int GAP_EFF = (GAP < GAP_MIN) ? GAP_MIN : GAP;
  localparam int GW      = gap_cnt_width(GAP_EFF);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_EFF - 1);

  state_t        state, state_nxt;
  logic [HW-1:0] hact_q;
  logic [VW-1:0] vact_q;
  logic [GW-1:0] gcnt;
  logic          first_q;
  logic          abort_q;
  logic          cfg_err_q;
  logic          valid_q, sof_q, eol_q;

  logic ord_en, ialign, lend_force, done_c;
  logic h_inc, h_clr, v_inc, v_clr;
  logic h_last, v_last;
  logic accept, cfg_bad, geom_zero;

  assign geom_zero = (cfg_hactive == '0) || (cfg_vactive == '0);

  dctrl_xy_cnt #(.HW(HW), .VW(VW)) u_xy_cnt (
    .clock   (clock),
    .rst_n   (rst_n),
    .h_inc   (h_inc),
    .h_clr   (h_clr),
    .v_inc   (v_inc),
    .v_clr   (v_clr),
    .h_total (hact_q),
    .v_total (vact_q),
    .h_last  (h_last),
    .v_last  (v_last)
  );

  always_comb begin
    state_nxt  = state;
    ord_en     = 1'b0;
    ialign     = 1'b0;
    lend_force = 1'b0;
    done_c     = 1'b0;
    h_inc      = 1'b0;
    h_clr      = 1'b0;
    v_inc      = 1'b0;
    v_clr      = 1'b0;
    accept     = 1'b0;
    cfg_bad    = 1'b0;
    // Abort masks every strobe this cycle; the force-read follows next cycle.
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (geom_zero) begin
              cfg_bad = 1'b1;
            end else begin
              accept    = 1'b1;
              state_nxt = ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          ialign    = 1'b1;
          h_clr     = 1'b1;
          v_clr     = 1'b1;
          state_nxt = ST_RUN;
        end
        ST_RUN: begin
          ord_en = !dst.fifo_empty && dst.pix_ready;
          if (ord_en) begin
            if (h_last) begin
              h_clr     = 1'b1;
              state_nxt = ST_LEND;
            end else begin
              h_inc = 1'b1;
            end
          end
        end
        ST_LEND: begin
`ifdef DESTRUCT_LINE_ALIGN_EN
          lend_force = 1'b1;
`else
          lend_force = v_last;
`endif
          if (v_last) begin
            state_nxt = ST_DONE;
          end else begin
            v_inc     = 1'b1;
            state_nxt = ST_GAPW;
          end
        end
        ST_GAPW: begin
          if (gcnt == '0) state_nxt = ST_RUN;
        end
        ST_DONE: begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hact_q    <= '0;
      vact_q    <= '0;
      gcnt      <= '0;
      first_q   <= 1'b0;
      abort_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      abort_q   <= abort && (state != ST_IDLE);
      cfg_err_q <= cfg_bad;
      if (accept) begin
        hact_q <= cfg_hactive;
        vact_q <= cfg_vactive;
      end
      if (state == ST_LEND)                   gcnt <= GAP_LOAD;
      else if (state == ST_GAPW && gcnt != '0) gcnt <= gcnt - GW'(1);
      if (ialign)      first_q <= 1'b1;
      else if (ord_en) first_q <= 1'b0;
      // Mirrors the destructor's one-cycle output register.
      valid_q <= ord_en;
      sof_q   <= ord_en && first_q;
      eol_q   <= ord_en && h_last;
    end
  end

  assign dst.dst_ord_en   = ord_en;
  assign dst.dst_ialign   = ialign;
  assign dst.dst_force_rd = lend_force || abort_q;
  assign dst.pix_valid    = valid_q;
  assign dst.pix_sof      = sof_q;
  assign dst.pix_eol      = eol_q;
  assign busy       = (state == ST_ALIGN) || (state == ST_RUN) ||
                      (state == ST_LEND)  || (state == ST_GAPW);
  assign frame_done = done_c;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_destruct_line_ctrl.sv
// Randomized bench for destruct_line_ctrl against a pixel-schedule reference model.
module tb_destruct_line_ctrl;
  localparam int HW = 16;
  localparam int VW = 16;
  localparam int GAP = 2;
  localparam int MAXC = 600;
`ifdef DESTRUCT_LINE_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  localparam int B_ORD = 0, B_IAL = 1, B_FRC = 2, B_VAL = 3, B_SOF = 4,
                 B_EOL = 5, B_BUSY = 6, B_DONE = 7, B_ERR = 8;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [HW-1:0] cfg_hactive = '0;
  logic [VW-1:0] cfg_vactive = '0;
  logic start = 1'b0, abort = 1'b0;
  logic busy, frame_done, cfg_err;

  destruct_line_ctrl_if dif();

  destruct_line_ctrl #(.HW(HW), .VW(VW), .GAP(GAP)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .cfg_hactive (cfg_hactive),
    .cfg_vactive (cfg_vactive),
    .start       (start),
    .abort       (abort),
    .dst         (dif),
    .busy        (busy),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err)
  );

  always #5 clock = ~clock;

  bit in_empty[MAXC], in_ready[MAXC], in_start[MAXC], in_abort[MAXC];
  logic [8:0] obs[MAXC];
  bit   [8:0] expv[MAXC];
  int tests = 0, failed = 0;

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      in_empty[k] = 1'b0; in_ready[k] = 1'b1; in_start[k] = 1'b0; in_abort[k] = 1'b0;
      expv[k] = '0;
    end
  endtask

  task automatic rand_stall();
    for (int k = 0; k < MAXC; k++) begin
      in_empty[k] = ($urandom_range(0, 3) == 0);
      in_ready[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Walks the frame pixel by pixel; start is assumed at cycle 0. Returns the done cycle or -1.
  function automatic int build(input int h, input int v, input int abort_at);
    int c, done_c;
    for (int k = 0; k < MAXC; k++) expv[k] = '0;
    expv[1][B_IAL] = 1'b1; expv[1][B_BUSY] = 1'b1;
    c = 2;
    for (int l = 0; l < v; l++) begin
      for (int p = 0; p < h; p++) begin
        while (in_empty[c] || !in_ready[c]) begin
          expv[c][B_BUSY] = 1'b1;
          c++;
          if (c >= MAXC - 8) return -1;
        end
        expv[c][B_ORD] = 1'b1; expv[c][B_BUSY] = 1'b1;
        expv[c+1][B_VAL] = 1'b1;
        expv[c+1][B_SOF] = (l == 0 && p == 0);
        expv[c+1][B_EOL] = (p == h - 1);
        c++;
      end
      expv[c][B_BUSY] = 1'b1;
      expv[c][B_FRC]  = (l == v - 1) || ALIGN_EN;
      c++;
      if (l < v - 1) for (int g = 0; g < GAP; g++) begin expv[c][B_BUSY] = 1'b1; c++; end
      if (c >= MAXC - 8) return -1;
    end
    expv[c][B_DONE] = 1'b1;
    done_c = c;
    if (abort_at > 0) begin
      for (int k = abort_at; k < MAXC; k++) begin
        expv[k][B_ORD] = 1'b0; expv[k][B_IAL] = 1'b0; expv[k][B_FRC] = 1'b0; expv[k][B_DONE] = 1'b0;
        if (k > abort_at) begin
          expv[k][B_BUSY] = 1'b0; expv[k][B_VAL] = 1'b0; expv[k][B_SOF] = 1'b0; expv[k][B_EOL] = 1'b0;
        end
      end
      expv[abort_at+1][B_FRC] = 1'b1;
    end
    return done_c;
  endfunction

  // Applies stimulus row k after the edge, samples outputs on the falling edge.
  task automatic drive(input int h, input int v, input int n);
    cfg_hactive = HW'(h);
    cfg_vactive = VW'(v);
    for (int k = 0; k < n; k++) begin
      start = in_start[k]; abort = in_abort[k];
      dif.fifo_empty = in_empty[k]; dif.pix_ready = in_ready[k];
      @(negedge clock);
      obs[k] = {cfg_err, frame_done, busy, dif.pix_eol, dif.pix_sof, dif.pix_valid,
                dif.dst_force_rd, dif.dst_ialign, dif.dst_ord_en};
      @(posedge clock); #1;
    end
    start = 1'b0; abort = 1'b0; dif.fifo_empty = 1'b0; dif.pix_ready = 1'b1;
  endtask

  function automatic int count(input int b, input int n);
    int s = 0;
    for (int k = 0; k < n; k++) if (obs[k][b] === 1'b1) s++;
    return s;
  endfunction

  task automatic test_reset();
    logic [8:0] r;
    rst_n = 1'b0; start = 1'b1; abort = 1'b1;
    cfg_hactive = 4; cfg_vactive = 2; dif.fifo_empty = 1'b0; dif.pix_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    r = {cfg_err, frame_done, busy, dif.pix_eol, dif.pix_sof, dif.pix_valid,
         dif.dst_force_rd, dif.dst_ialign, dif.dst_ord_en};
    for (int b = 0; b < 9; b++) begin
      tests++;
      if (r[b] !== 1'b0) begin failed++; $display("FAIL reset bit %0d: got %b want 0", b, r[b]); end
    end
    start = 1'b0; abort = 1'b0;
    @(posedge clock); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic_4x2();
    int d, n;
    clear_stim(); in_start[0] = 1'b1;
    d = build(4, 2, 0); n = d + 4;
    drive(4, 2, n);
    for (int k = 0; k < n; k++) begin
      tests++;
      if (obs[k] !== expv[k]) begin failed++; $display("FAIL basic_4x2 cycle %0d: got %b want %b", k, obs[k], expv[k]); end
    end
    tests++; if (count(B_VAL, n) != 8) begin failed++; $display("FAIL basic_4x2 valid_count: got %0d want 8", count(B_VAL, n)); end
    tests++; if (count(B_EOL, n) != 2) begin failed++; $display("FAIL basic_4x2 eol_count: got %0d want 2", count(B_EOL, n)); end
  endtask

  task automatic test_fifo_stall();
    int d, n;
    clear_stim(); in_start[0] = 1'b1;
    for (int k = 5; k <= 7; k++) in_empty[k] = 1'b1;
    d = build(6, 1, 0); n = d + 4;
    drive(6, 1, n);
    for (int k = 0; k < n; k++) begin
      tests++;
      if (obs[k] !== expv[k]) begin failed++; $display("FAIL fifo_stall cycle %0d: got %b want %b", k, obs[k], expv[k]); end
    end
    tests++; if (count(B_VAL, n) != 6) begin failed++; $display("FAIL fifo_stall valid_count: got %0d want 6", count(B_VAL, n)); end
  endtask

  task automatic test_ready_toggle();
    int d, n;
    clear_stim(); in_start[0] = 1'b1;
    for (int k = 0; k < MAXC; k++) in_ready[k] = k[0];
    d = build(8, 1, 0); n = d + 4;
    drive(8, 1, n);
    for (int k = 0; k < n; k++) begin
      tests++;
      if (obs[k] !== expv[k]) begin failed++; $display("FAIL ready_toggle cycle %0d: got %b want %b", k, obs[k], expv[k]); end
    end
  endtask

  task automatic test_cfg_err();
    int d, n;
    clear_stim(); in_start[0] = 1'b1;
    expv[1][B_ERR] = 1'b1;
    drive(0, 3, 6);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (obs[k] !== expv[k]) begin failed++; $display("FAIL cfg_err_zero cycle %0d: got %b want %b", k, obs[k], expv[k]); end
    end
    clear_stim(); rand_stall(); in_start[0] = 1'b1;
    d = build(3, 3, 0);
    if (d < 0) begin tests++; failed++; $display("FAIL cfg_err_3x3 schedule overflow: got -1 want >0"); return; end
    in_start[$urandom_range(2, d)] = 1'b1;
    n = d + 4;
    drive(3, 3, n);
    for (int k = 0; k < n; k++) begin
      tests++;
      if (obs[k] !== expv[k]) begin failed++; $display("FAIL cfg_err_3x3 cycle %0d: got %b want %b", k, obs[k], expv[k]); end
    end
    tests++; if (count(B_VAL, n) != 9) begin failed++; $display("FAIL cfg_err_3x3 valid_count: got %0d want 9", count(B_VAL, n)); end
  endtask

  task automatic test_abort();
    int d, n, seen, abort_at;
    clear_stim(); rand_stall(); in_start[0] = 1'b1;
    d = build(5, 4, 0);
    if (d < 0) begin tests++; failed++; $display("FAIL abort schedule overflow: got -1 want >0"); return; end
    seen = 0; abort_at = 0;
    for (int k = 0; k < MAXC; k++) if (expv[k][B_ORD]) begin seen++; if (seen == 7) abort_at = k; end
    d = build(5, 4, abort_at);
    in_abort[abort_at] = 1'b1;
    n = abort_at + 6;
    drive(5, 4, n);
    for (int k = 0; k < n; k++) begin
      tests++;
      if (obs[k] !== expv[k]) begin failed++; $display("FAIL abort cycle %0d: got %b want %b", k, obs[k], expv[k]); end
    end
    tests++; if (count(B_DONE, n) != 0) begin failed++; $display("FAIL abort done_count: got %0d want 0", count(B_DONE, n)); end
    clear_stim(); in_start[0] = 1'b1;
    d = build(2, 2, 0); n = d + 4;
    drive(2, 2, n);
    tests++; if (obs[1][B_IAL] !== 1'b1) begin failed++; $display("FAIL abort_restart ialign: got %b want 1", obs[1][B_IAL]); end
    for (int k = 0; k < n; k++) begin
      tests++;
      if (obs[k] !== expv[k]) begin failed++; $display("FAIL abort_restart cycle %0d: got %b want %b", k, obs[k], expv[k]); end
    end
  endtask

  task automatic test_abort_start();
    clear_stim(); in_start[0] = 1'b1; in_abort[0] = 1'b1;
    drive(3, 3, 8);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (obs[k] !== expv[k]) begin failed++; $display("FAIL abort_start cycle %0d: got %b want %b", k, obs[k], expv[k]); end
    end
  endtask

  task automatic test_force_count();
    int d, n, want;
    clear_stim(); in_start[0] = 1'b1;
    d = build(3, 3, 0); n = d + 4;
    drive(3, 3, n);
    want = ALIGN_EN ? 3 : 1;
    tests++; if (count(B_FRC, n) != want) begin failed++; $display("FAIL force_count: got %0d want %0d", count(B_FRC, n), want); end
    for (int k = 0; k < n; k++) begin
      tests++;
      if (obs[k] !== expv[k]) begin failed++; $display("FAIL force_3x3 cycle %0d: got %b want %b", k, obs[k], expv[k]); end
    end
  endtask

  task automatic test_random();
    int d, n, h, v;
    for (int t = 0; t < 8; t++) begin
      h = (t == 0) ? 1 : $urandom_range(1, 7);
      v = $urandom_range(1, 4);
      clear_stim(); rand_stall(); in_start[0] = 1'b1;
      d = build(h, v, 0);
      tests++;
      if (d < 0) begin failed++; $display("FAIL random_%0d schedule overflow: got -1 want >0", t); continue; end
      in_start[$urandom_range(2, d)] = 1'b1;
      n = d + 4;
      drive(h, v, n);
      for (int k = 0; k < n; k++) begin
        tests++;
        if (obs[k] !== expv[k]) begin failed++; $display("FAIL random_%0d (%0dx%0d) cycle %0d: got %b want %b", t, h, v, k, obs[k], expv[k]); end
      end
    end
  endtask

  task automatic test_midframe_reset();
    clear_stim(); in_start[0] = 1'b1;
    drive(4, 2, 6);
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    clear_stim();
    drive(4, 2, 20);
    for (int k = 0; k < 20; k++) begin
      tests++;
      if (obs[k] !== expv[k]) begin failed++; $display("FAIL midframe_reset cycle %0d: got %b want %b", k, obs[k], expv[k]); end
    end
  endtask

  initial begin
    dif.fifo_empty = 1'b0;
    dif.pix_ready  = 1'b1;
    test_reset();
    test_basic_4x2();
    test_fifo_stall();
    test_ready_toggle();
    test_cfg_err();
    test_abort();
    test_abort_start();
    test_force_count();
    test_random();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish want finish before 1ms");
    $fatal(1);
  end

endmodule
